// File: rtl/txt_mem_arbiter.sv
// rtl/txt_mem_arbiter.sv - single-port text memory arbiter: video fetch priority, CPU write FIFO, clear engine
module txt_mem_arbiter #(
    parameter int          ADDR_W     = 12,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CELLS      = 1200,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              cpu_wr_valid,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,
    input  logic              cpu_clr_req,
    output logic              busy,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  ONE_P     = PTR_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cc;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              head_ok;

    assign cpu_wr_ready = (state == IDLE) && (count < DEPTH_C);
    assign busy         = (state == CLEARING) || (count != '0);
    assign push         = cpu_wr_valid && cpu_wr_ready;
    assign pop          = (state == IDLE) && !vid_req && (count != '0);
    assign head_ok      = fifo_addr[rd_ptr] < CELLS_A;

    // Port mux: video fetch always wins, then the clear engine, then the FIFO head.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = vid_addr;
        mem_wdata = fifo_data[rd_ptr];
        if (vid_req) begin
            mem_en = 1'b1;
        end else if (state == CLEARING) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cc;
            mem_wdata = DATA_W'(FILL_CHAR);
        end else if (pop && head_ok) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = fifo_addr[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cc       <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            addr_err <= 1'b0;
        end else begin
            if (pop && !head_ok) begin
                addr_err <= 1'b1;
            end
            if (cpu_clr_req) begin
                // A clear request discards queued and same-cycle writes and restarts from cell 0.
                state  <= CLEARING;
                cc     <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (state == CLEARING && !vid_req) begin
                    if (cc == LAST_CELL) begin
                        state <= IDLE;
                        cc    <= '0;
                    end else begin
                        cc <= cc + ONE_A;
                    end
                end
                if (push) begin
                    fifo_addr[wr_ptr] <= cpu_wr_addr;
                    fifo_data[wr_ptr] <= cpu_wr_data;
                    wr_ptr            <= wr_ptr + ONE_P;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ONE_P;
                end
                case ({push, pop})
                    2'b10:   count <= count + ONE_C;
                    2'b01:   count <= count - ONE_C;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_txt_mem_arbiter.sv
// tb/tb_txt_mem_arbiter.sv - directed self-checking bench for txt_mem_arbiter
module tb_txt_mem_arbiter;
    logic        clk = 1'b0;
    logic        clr;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        cpu_wr_valid;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ready;
    logic        cpu_clr_req;
    logic        busy;
    logic        addr_err;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    int total = 0;
    int bad   = 0;
    int n;
    int errs;
    int k;

    txt_mem_arbiter dut (
        .clk         (clk),
        .clr         (clr),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .cpu_wr_valid(cpu_wr_valid),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready),
        .cpu_clr_req (cpu_clr_req),
        .busy        (busy),
        .addr_err    (addr_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_clr_req = 1'b0;
        cyc(); cyc();
        clr = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", cpu_wr_ready, 1);
        check("rst_addr_err", addr_err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        cyc();

        // Video fetch passes through in the same cycle
        vid_req = 1'b1; vid_addr = 12'h04B;
        #1;
        check("vid_en", mem_en, 1);
        check("vid_we", mem_we, 0);
        check("vid_addr", mem_addr, 12'h04B);
        cyc();

        // Write blocked by three fetch cycles
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h010; cpu_wr_data = 8'h41;
        #1;
        check("coll_ready", cpu_wr_ready, 1);
        check("coll_we_push", mem_we, 0);
        cyc();
        cpu_wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("coll_we_blocked", mem_we, 0);
            check("coll_busy", busy, 1);
            cyc();
        end
        vid_req = 1'b0;
        #1;
        check("coll_en", mem_en, 1);
        check("coll_we", mem_we, 1);
        check("coll_addr", mem_addr, 12'h010);
        check("coll_data", mem_wdata, 8'h41);
        cyc();
        #1;
        check("coll_busy_drop", busy, 0);
        check("coll_idle_we", mem_we, 0);
        cyc();

        // FIFO full: five pushes under continuous video
        vid_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h100 + 12'(i); cpu_wr_data = 8'h60 + 8'(i);
            #1;
            check("full_ready", cpu_wr_ready, (i < 4) ? 1 : 0);
            cyc();
        end
        cpu_wr_valid = 1'b0;
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_we", mem_we, 1);
            check("drain_addr", mem_addr, 32'h100 + i);
            check("drain_data", mem_wdata, 32'h60 + i);
            cyc();
        end
        #1;
        check("drain_done_we", mem_we, 0);
        check("drain_done_busy", busy, 0);
        cyc();

        // Out-of-range write is dropped and flagged
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'd1200; cpu_wr_data = 8'h55;
        cyc();
        cpu_wr_valid = 1'b0;
        #1;
        check("oor_en", mem_en, 0);
        check("oor_we", mem_we, 0);
        check("oor_err_pre", addr_err, 0);
        cyc();
        #1;
        check("oor_err", addr_err, 1);
        check("oor_busy", busy, 0);
        cyc(); cyc();
        #1;
        check("oor_err_sticky", addr_err, 1);
        cyc();

        // Clear with 1-in-8 video interleave after queueing two writes
        vid_req = 1'b1;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h200; cpu_wr_data = 8'h11;
        cyc();
        cpu_wr_addr = 12'h201; cpu_wr_data = 8'h12;
        cyc();
        cpu_wr_valid = 1'b0;
        cpu_clr_req = 1'b1;
        cyc();
        cpu_clr_req = 1'b0;
        #1;
        check("clr_ready", cpu_wr_ready, 0);
        check("clr_busy", busy, 1);
        n = 0; errs = 0; k = 0;
        while (n < 1200 && k < 2000) begin
            vid_req = (k % 8 == 0);
            vid_addr = 12'h3FF;
            #1;
            if (vid_req) begin
                if (mem_we !== 1'b0) errs++;
            end else if (mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 12'(n) && mem_wdata === 8'h20) begin
                n++;
            end else begin
                errs++;
            end
            k++;
            cyc();
        end
        vid_req = 1'b0;
        #1;
        check("clr_writes", n, 1200);
        check("clr_errs", errs, 0);
        check("clr_end_we", mem_we, 0);
        check("clr_end_busy", busy, 0);
        check("clr_end_ready", cpu_wr_ready, 1);
        check("clr_err_sticky", addr_err, 1);
        cyc();

        // Restart at cc=500, then reset at cc=300
        cpu_clr_req = 1'b1;
        cyc();
        cpu_clr_req = 1'b0;
        for (int i = 0; i < 600; i++) begin
            #1;
            if (mem_addr === 12'd500) break;
            cyc();
        end
        check("rs_at500", mem_addr, 500);
        cpu_clr_req = 1'b1;
        cyc();
        cpu_clr_req = 1'b0;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (mem_we !== 1'b1 || mem_addr !== 12'(i)) errs++;
            cyc();
        end
        check("rs_restart_errs", errs, 0);
        #1;
        check("rs_at300", mem_addr, 300);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        #1;
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cpu_wr_ready, 1);
        check("abort_addr_err", addr_err, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
